// File: rtl/pdp8_pkg.sv
// pdp8_pkg: shared PDP-8 decode payload types and group-7 microinstruction encodings.
//   pdp_mem_opcode_s : one-hot memory-reference op (AND..JMP) plus 9-bit page/offset field
//   pdp_op7_opcode_s : one-hot group-7 (operate) microinstruction, exact-match encodings below
package pdp8_pkg;

  typedef struct packed {
    logic       AND;
    logic       TAD;
    logic       ISZ;
    logic       DCA;
    logic       JMS;
    logic       JMP;
    logic [8:0] mem_offset;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CLL;
    logic CLA1;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
    logic CLA2;
  } pdp_op7_opcode_s;

  // Group 1 operate
  localparam logic [11:0] OP_NOP  = 12'o7000;
  localparam logic [11:0] OP_IAC  = 12'o7001;
  localparam logic [11:0] OP_RAL  = 12'o7004;
  localparam logic [11:0] OP_RTL  = 12'o7006;
  localparam logic [11:0] OP_RAR  = 12'o7010;
  localparam logic [11:0] OP_RTR  = 12'o7012;
  localparam logic [11:0] OP_CML  = 12'o7020;
  localparam logic [11:0] OP_CMA  = 12'o7040;
  localparam logic [11:0] OP_CLL  = 12'o7100;
  localparam logic [11:0] OP_CLA1 = 12'o7200;
  // Group 2 operate
  localparam logic [11:0] OP_HLT  = 12'o7402;
  localparam logic [11:0] OP_OSR  = 12'o7404;
  localparam logic [11:0] OP_SKP  = 12'o7410;
  localparam logic [11:0] OP_SNL  = 12'o7420;
  localparam logic [11:0] OP_SZL  = 12'o7430;
  localparam logic [11:0] OP_SZA  = 12'o7440;
  localparam logic [11:0] OP_SNA  = 12'o7450;
  localparam logic [11:0] OP_SMA  = 12'o7500;
  localparam logic [11:0] OP_SPA  = 12'o7510;
  localparam logic [11:0] OP_CLA2 = 12'o7600;

endpackage

// File: rtl/pdp8_prefetch_ifu.sv
// pdp8_prefetch_ifu: PDP-8 instruction fetch unit with a QDEPTH-entry prefetch queue.
// Streams sequential reads ahead of the EU and decodes the queue head.
//   clk, reset_n               clock / async active-low reset
//   ifu_rd_req, ifu_rd_addr    registered memory read request; data returns one cycle later
//   ifu_rd_data                read data
//   instr_valid, instr_ack     head-of-queue handshake with the EU
//   base_addr                  PC of the presented instruction
//   pdp_mem_opcode/op7_opcode  decoded head (all-zero when !instr_valid)
//   redirect, redirect_pc      EU PC change: flush queue, squash in-flight read, refetch
//   ifu_halted                 HLT consumed; fetching stopped until redirect
// Optional feature macro IFU_STATS_EN adds fetch_count / flush_count saturating counters.
module pdp8_prefetch_ifu
  import pdp8_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           DATA_WIDTH = 12,
  parameter int unsigned           QDEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(12'o200)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  ifu_halted
`ifdef IFU_STATS_EN
  ,
  output logic [15:0]           fetch_count,
  output logic [15:0]           flush_count
`endif
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] q_pc   [QDEPTH];
  logic [DATA_WIDTH-1:0] q_data [QDEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, count_after_pop;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  resp_pend_q, resp_pend_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  rd_req_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic                  valid_d;
  logic [ADDR_WIDTH-1:0] base_addr_d;
  logic                  halted_d;
  logic [SW-1:0]         occupancy;
  logic                  credit_ok, hlt_ack, flush, pop, push, issue;
  logic [11:0]           word;

  // Head decode, straight from the registered head word.
  always_comb begin
    pdp_mem_opcode = '0;
    pdp_op7_opcode = '0;
    word           = head_data_q[11:0];
    if (instr_valid) begin
      case (word[11:9])
        3'd0: pdp_mem_opcode.AND = 1'b1;
        3'd1: pdp_mem_opcode.TAD = 1'b1;
        3'd2: pdp_mem_opcode.ISZ = 1'b1;
        3'd3: pdp_mem_opcode.DCA = 1'b1;
        3'd4: pdp_mem_opcode.JMS = 1'b1;
        3'd5: pdp_mem_opcode.JMP = 1'b1;
        3'd6: pdp_op7_opcode.NOP = 1'b1;
        default: begin
          case (word)
            OP_IAC:  pdp_op7_opcode.IAC  = 1'b1;
            OP_RAL:  pdp_op7_opcode.RAL  = 1'b1;
            OP_RTL:  pdp_op7_opcode.RTL  = 1'b1;
            OP_RAR:  pdp_op7_opcode.RAR  = 1'b1;
            OP_RTR:  pdp_op7_opcode.RTR  = 1'b1;
            OP_CML:  pdp_op7_opcode.CML  = 1'b1;
            OP_CMA:  pdp_op7_opcode.CMA  = 1'b1;
            OP_CLL:  pdp_op7_opcode.CLL  = 1'b1;
            OP_CLA1: pdp_op7_opcode.CLA1 = 1'b1;
            OP_HLT:  pdp_op7_opcode.HLT  = 1'b1;
            OP_OSR:  pdp_op7_opcode.OSR  = 1'b1;
            OP_SKP:  pdp_op7_opcode.SKP  = 1'b1;
            OP_SNL:  pdp_op7_opcode.SNL  = 1'b1;
            OP_SZL:  pdp_op7_opcode.SZL  = 1'b1;
            OP_SZA:  pdp_op7_opcode.SZA  = 1'b1;
            OP_SNA:  pdp_op7_opcode.SNA  = 1'b1;
            OP_SMA:  pdp_op7_opcode.SMA  = 1'b1;
            OP_SPA:  pdp_op7_opcode.SPA  = 1'b1;
            OP_CLA2: pdp_op7_opcode.CLA2 = 1'b1;
            default: pdp_op7_opcode.NOP  = 1'b1;
          endcase
        end
      endcase
      if (word[11:9] < 3'd6) pdp_mem_opcode.mem_offset = word[8:0];
    end
  end

  // Next-state logic: FSM, credit-based issue, queue push/pop, redirect/HLT flush.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = ifu_rd_addr;
    base_addr_d = base_addr;
    head_data_d = head_data_q;

    // In-flight reads occupy a slot from issue until they land, so overflow cannot happen.
    occupancy = SW'(count_q) + SW'(ifu_rd_req) + SW'(resp_pend_q);
    credit_ok = occupancy < SW'(QDEPTH);
    hlt_ack   = (state_q == ST_RUN) && instr_valid && instr_ack && pdp_op7_opcode.HLT && !redirect;
    flush     = redirect || hlt_ack;
    pop       = instr_valid && instr_ack && !redirect;
    push      = (state_q == ST_RUN) && resp_pend_q && !flush;
    issue     = (state_q == ST_RUN) && !flush && credit_ok;

    case (state_q)
      ST_IDLE:   state_d = ST_RUN;
      ST_RUN:    if (hlt_ack) state_d = ST_HALTED;
      ST_HALTED: if (redirect) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase

    if (issue) begin
      rd_req_d   = 1'b1;
      rd_addr_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
    end
    if (redirect) fetch_pc_d = redirect_pc;

    resp_pend_d = ifu_rd_req && !flush;
    resp_pc_d   = ifu_rd_addr;

    count_after_pop = count_q - CW'(pop);
    count_d         = count_after_pop + CW'(push);
    wr_ptr_d        = wr_ptr_q + PW'(push);
    rd_ptr_d        = rd_ptr_q + PW'(pop);

    // Next head: the surviving stored entry, else the word landing this cycle.
    if (count_after_pop != '0) begin
      base_addr_d = q_pc[rd_ptr_d];
      head_data_d = q_data[rd_ptr_d];
    end else if (push) begin
      base_addr_d = resp_pc_q;
      head_data_d = ifu_rd_data;
    end

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    valid_d  = (count_d != '0);
    halted_d = (state_d == ST_HALTED);
  end

  // Queue storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr_q]   <= resp_pc_q;
      q_data[wr_ptr_q] <= ifu_rd_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= START_ADDR;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      resp_pend_q <= 1'b0;
      resp_pc_q   <= '0;
      head_data_q <= '0;
      ifu_rd_req  <= 1'b0;
      ifu_rd_addr <= '0;
      instr_valid <= 1'b0;
      base_addr   <= START_ADDR;
      ifu_halted  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      resp_pend_q <= resp_pend_d;
      resp_pc_q   <= resp_pc_d;
      head_data_q <= head_data_d;
      ifu_rd_req  <= rd_req_d;
      ifu_rd_addr <= rd_addr_d;
      instr_valid <= valid_d;
      base_addr   <= base_addr_d;
      ifu_halted  <= halted_d;
    end
  end

`ifdef IFU_STATS_EN
  logic [SW-1:0] discard;
  logic [16:0]   fetch_sum, flush_sum;

  // Discarded = queued + in flight, less the HLT itself when it was consumed.
  always_comb begin
    discard   = occupancy - SW'(hlt_ack);
    fetch_sum = {1'b0, fetch_count} + 17'(issue);
    flush_sum = {1'b0, flush_count} + 17'(discard);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      fetch_count <= fetch_sum[16] ? 16'hFFFF : fetch_sum[15:0];
      if (flush) flush_count <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_pdp8_prefetch_ifu.sv
// tb_pdp8_prefetch_ifu: scoreboard bench for pdp8_prefetch_ifu with a one-cycle-latency memory model.
module tb_pdp8_prefetch_ifu;
  import pdp8_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data;
  logic        instr_valid;
  logic        instr_ack;
  logic [11:0] base_addr;
  pdp_mem_opcode_s pdp_mem_opcode;
  pdp_op7_opcode_s pdp_op7_opcode;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        ifu_halted;
`ifdef IFU_STATS_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  pdp8_prefetch_ifu dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ifu_rd_req     (ifu_rd_req),
    .ifu_rd_addr    (ifu_rd_addr),
    .ifu_rd_data    (ifu_rd_data),
    .instr_valid    (instr_valid),
    .instr_ack      (instr_ack),
    .base_addr      (base_addr),
    .pdp_mem_opcode (pdp_mem_opcode),
    .pdp_op7_opcode (pdp_op7_opcode),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .ifu_halted     (ifu_halted)
`ifdef IFU_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]     pc;
    pdp_mem_opcode_s m;
    pdp_op7_opcode_s o;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] req_log[$];
  logic [11:0] mem [4096];
  int          checks = 0;
  int          errors = 0;
  int          req_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: data for a request appears the cycle after ifu_rd_req is seen.
  always @(posedge clk) begin
    if (ifu_rd_req) ifu_rd_data <= mem[ifu_rd_addr];
  end

  // Monitor: pops the scoreboard on every handshake; idle decode must be all-zero.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (instr_valid && instr_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %0o expected none", base_addr);
        end else begin
          e = exp_q.pop_front();
          check("base_addr", 32'(base_addr), 32'(e.pc));
          check("mem_opcode", 32'(pdp_mem_opcode), 32'(e.m));
          check("op7_opcode", 32'(pdp_op7_opcode), 32'(e.o));
        end
      end else if (!instr_valid) begin
        check("idle_mem_zero", 32'(pdp_mem_opcode), 32'd0);
        check("idle_op7_zero", 32'(pdp_op7_opcode), 32'd0);
      end
      if (ifu_rd_req) begin
        req_count++;
        req_log.push_back(ifu_rd_addr);
      end
    end
  end

  task automatic exp_mem(input logic [11:0] pc, input string n, input logic [8:0] off);
    exp_t e;
    e.pc = pc;
    e.m  = '0;
    e.o  = '0;
    case (n)
      "AND": e.m.AND = 1'b1;
      "TAD": e.m.TAD = 1'b1;
      "ISZ": e.m.ISZ = 1'b1;
      "DCA": e.m.DCA = 1'b1;
      "JMS": e.m.JMS = 1'b1;
      default: e.m.JMP = 1'b1;
    endcase
    e.m.mem_offset = off;
    exp_q.push_back(e);
  endtask

  task automatic exp_op7(input logic [11:0] pc, input string n);
    exp_t e;
    e.pc = pc;
    e.m  = '0;
    e.o  = '0;
    case (n)
      "IAC":  e.o.IAC  = 1'b1;
      "RAL":  e.o.RAL  = 1'b1;
      "RTL":  e.o.RTL  = 1'b1;
      "RAR":  e.o.RAR  = 1'b1;
      "RTR":  e.o.RTR  = 1'b1;
      "CML":  e.o.CML  = 1'b1;
      "CMA":  e.o.CMA  = 1'b1;
      "CLL":  e.o.CLL  = 1'b1;
      "CLA1": e.o.CLA1 = 1'b1;
      "HLT":  e.o.HLT  = 1'b1;
      "SKP":  e.o.SKP  = 1'b1;
      "CLA2": e.o.CLA2 = 1'b1;
      default: e.o.NOP = 1'b1;
    endcase
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold ack until n instructions are consumed; bubbles = ack cycles with nothing valid.
  task automatic consume(input int n, output int bubbles);
    int got = 0;
    int cyc = 0;
    bubbles = 0;
    instr_ack = 1'b1;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (instr_valid) got++;
      else bubbles++;
    end
    if (got < n) check("consume_timeout", 32'(got), 32'(n));
    @(posedge clk);
    #1;
    instr_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int b;
    int rc;
    for (int i = 0; i < 4096; i++) mem[i] = 12'o7000;
    mem[12'o0201] = 12'o1234; mem[12'o0202] = 12'o7001; mem[12'o0204] = 12'o0123;
    mem[12'o0205] = 12'o2377; mem[12'o0206] = 12'o3400; mem[12'o0207] = 12'o4010;
    mem[12'o0210] = 12'o5177; mem[12'o0211] = 12'o6031; mem[12'o0212] = 12'o7300;
    mem[12'o0213] = 12'o7200; mem[12'o0214] = 12'o7410; mem[12'o0215] = 12'o7600;
    mem[12'o3000] = 12'o1100; mem[12'o3001] = 12'o7004; mem[12'o3002] = 12'o7010;
    mem[12'o3003] = 12'o7020;
    mem[12'o7776] = 12'o7040; mem[12'o7777] = 12'o7100; mem[12'o0000] = 12'o7006;
    mem[12'o0001] = 12'o7012;
    mem[12'o4000] = 12'o7402;

    reset_n = 1'b0; instr_ack = 1'b0; redirect = 1'b0; redirect_pc = '0; ifu_rd_data = '0;

    // Reset state
    @(negedge clk);
    check("rst_rd_req", 32'(ifu_rd_req), 32'd0);
    check("rst_rd_addr", 32'(ifu_rd_addr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_base_addr", 32'(base_addr), 32'o200);
    check("rst_mem_op", 32'(pdp_mem_opcode), 32'd0);
    check("rst_op7_op", 32'(pdp_op7_opcode), 32'd0);
    check("rst_halted", 32'(ifu_halted), 32'd0);
    reset_n = 1'b1;

    // Startup latency: request on edge 2, valid on edge 4
    step(1);
    check("e1_rd_req", 32'(ifu_rd_req), 32'd0);
    step(1);
    check("e2_rd_req", 32'(ifu_rd_req), 32'd1);
    check("e2_rd_addr", 32'(ifu_rd_addr), 32'o200);
    step(1);
    check("e3_valid", 32'(instr_valid), 32'd0);
    step(1);
    check("e4_valid", 32'(instr_valid), 32'd1);
    check("e4_base_addr", 32'(base_addr), 32'o200);

    // Stall: exactly QDEPTH requests, then nothing
    step(8);
    check("stall_req_count", 32'(req_count), 32'd4);
    check("stall_rd_req", 32'(ifu_rd_req), 32'd0);
    check("stall_valid", 32'(instr_valid), 32'd1);
`ifdef IFU_STATS_EN
    check("stall_fetch_count", 32'(fetch_count), 32'd4);
`endif

    // Decode sweep at one instruction per cycle
    exp_op7(12'o0200, "NOP");
    exp_mem(12'o0201, "TAD", 9'o234);
    exp_op7(12'o0202, "IAC");
    exp_op7(12'o0203, "NOP");
    exp_mem(12'o0204, "AND", 9'o123);
    exp_mem(12'o0205, "ISZ", 9'o377);
    exp_mem(12'o0206, "DCA", 9'o400);
    exp_mem(12'o0207, "JMS", 9'o010);
    exp_mem(12'o0210, "JMP", 9'o177);
    exp_op7(12'o0211, "NOP");
    exp_op7(12'o0212, "NOP");
    exp_op7(12'o0213, "CLA1");
    exp_op7(12'o0214, "SKP");
    exp_op7(12'o0215, "CLA2");
    consume(14, b);
    check("stream_bubbles", 32'(b), 32'd0);

    // Redirect with 2 queued + 1 in flight
    step(8);
    exp_op7(12'o0216, "NOP");
    exp_op7(12'o0217, "NOP");
    consume(2, b);
    redirect = 1'b1; redirect_pc = 12'o3000;
    step(1);
    redirect = 1'b0;
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_rd_req", 32'(ifu_rd_req), 32'd0);
`ifdef IFU_STATS_EN
    check("redir_flush_count", 32'(flush_count), 32'd3);
`endif
    step(1);
    check("redir_first_req", 32'(ifu_rd_req), 32'd1);
    check("redir_first_addr", 32'(ifu_rd_addr), 32'o3000);
    exp_mem(12'o3000, "TAD", 9'o100);
    exp_op7(12'o3001, "RAL");
    exp_op7(12'o3002, "RAR");
    exp_op7(12'o3003, "CML");
    consume(4, b);

    // PC wrap 7776 -> 0001
    step(8);
    redirect = 1'b1; redirect_pc = 12'o7776;
    step(1);
    redirect = 1'b0;
    req_log.delete();
    exp_op7(12'o7776, "CMA");
    exp_op7(12'o7777, "CLL");
    exp_op7(12'o0000, "RTL");
    exp_op7(12'o0001, "RTR");
    consume(4, b);
    check("wrap_req_log_size", 32'(req_log.size() >= 4), 32'd1);
    if (req_log.size() >= 4) begin
      check("wrap_addr0", 32'(req_log[0]), 32'o7776);
      check("wrap_addr1", 32'(req_log[1]), 32'o7777);
      check("wrap_addr2", 32'(req_log[2]), 32'o0000);
      check("wrap_addr3", 32'(req_log[3]), 32'o0001);
    end

    // HLT: stop fetching until redirect
    step(8);
    redirect = 1'b1; redirect_pc = 12'o4000;
    step(1);
    redirect = 1'b0;
`ifdef IFU_STATS_EN
    check("pre_hlt_flush_count", 32'(flush_count), 32'd11);
`endif
    exp_op7(12'o4000, "HLT");
    consume(1, b);
    check("hlt_halted", 32'(ifu_halted), 32'd1);
    check("hlt_valid", 32'(instr_valid), 32'd0);
    check("hlt_rd_req", 32'(ifu_rd_req), 32'd0);
`ifdef IFU_STATS_EN
    check("hlt_flush_count", 32'(flush_count), 32'd13);
`endif
    rc = req_count;
    step(6);
    check("halted_no_req", 32'(req_count), 32'(rc));
    check("halted_hold", 32'(ifu_halted), 32'd1);

    redirect = 1'b1; redirect_pc = 12'o0200;
    step(1);
    redirect = 1'b0;
    check("resume_halted", 32'(ifu_halted), 32'd0);
    req_log.delete();
    exp_op7(12'o0200, "NOP");
    consume(1, b);
    check("resume_req_seen", 32'(req_log.size() >= 1), 32'd1);
    if (req_log.size() >= 1) check("resume_addr", 32'(req_log[0]), 32'o0200);
`ifdef IFU_STATS_EN
    check("fetch_count_total", 32'(fetch_count), 32'(req_count));
`endif
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
